mult_hazard_ctrl: RTL and testbench

Sequencing controller for the non-pipelined multi-cycle multiplier that feeds the hi/lo registers of the five-stage MIPS pipeline. It issues a one-cycle start pulse when a `mult`/`multu` leaves Decode and counts the multiplier latency. It asserts the hi/lo write strobe when the product is ready. It stalls Fetch/Decode and bubbles Execute whenever a second multiply or an `mfhi`/`mflo` reaches Decode while a product is still in flight.

---
 rtl/mult_ctrl_pkg.sv | 13 +
 rtl/lat_downcounter.sv | 46 ++++
 rtl/mult_hazard_ctrl.sv | 92 +++++++++
 tb/tb_mult_hazard_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the multiplier sequencing logic.
//   state_t      : controller state encoding (S_IDLE / S_BUSY)
//   MULT_LATENCY : default multiplier latency, also used by the multiplier wrapper
package mult_ctrl_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam int unsigned MULT_LATENCY = 4;

endpackage

// File: rtl/lat_downcounter.sv
// Latency down-counter for the multiplier controller.
// Ports:
//   clk      : clock, state on rising edge
//   reset    : asynchronous active-high reset, clears the count
//   load     : load load_val this edge (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one this edge; saturates at 0
//   cnt      : current count
//   is_one   : cnt == 1, i.e. the last cycle of the count
module lat_downcounter #(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          is_one
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            // Never wraps: the count stops at zero.
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign is_one = (cnt_q == CW'(1));

endmodule

// File: rtl/mult_hazard_ctrl.sv
// Sequencing and hazard controller for the non-pipelined multi-cycle multiplier that feeds
// hi/lo. Issues a start pulse when a mult leaves Decode, counts the latency, strobes the
// hi/lo write when the product is ready, and stalls F/D plus bubbles E when another mult
// or an mfhi/mflo reaches Decode while a product is in flight.
// Ports:
//   clk, reset  : clock; asynchronous active-high reset
//   multD       : Decode holds mult/multu
//   mfhiloD     : Decode holds mfhi/mflo
//   stall_ext   : Decode held by another hazard source this cycle
//   flushD      : Decode instruction squashed this cycle
//   mult_start  : one-cycle pulse, multiplier latches operands from Execute
//   hilo_we     : one-cycle pulse, hi/lo capture the product this edge
//   busy        : product in flight
//   stallF      : hold PC
//   stallD      : hold F->D register
//   flushE      : clear D->E register (bubble)
//   cycles_left : remaining latency count
module mult_hazard_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = MULT_LATENCY,
    parameter int unsigned CW      = $clog2(LATENCY + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          multD,
    input  logic          mfhiloD,
    input  logic          stall_ext,
    input  logic          flushD,
    output logic          mult_start,
    output logic          hilo_we,
    output logic          busy,
    output logic          stallF,
    output logic          stallD,
    output logic          flushE,
    output logic [CW-1:0] cycles_left
);

    localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY);

    state_t        state_q;
    state_t        state_d;
    logic          issue;
    logic          in_busy;
    logic          hz;
    logic [CW-1:0] cnt;
    logic          cnt_is_one;

    lat_downcounter #(
        .CW (CW)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (issue),
        .load_val (LOAD_VAL),
        .dec      (in_busy),
        .cnt      (cnt),
        .is_one   (cnt_is_one)
    );

    assign in_busy = (state_q == S_BUSY);

    always_comb begin
        // Gated by reset so the combinational start pulse is also quiet while reset is held.
        issue   = !reset && (state_q == S_IDLE) && multD && !stall_ext && !flushD;
        state_d = state_q;
        case (state_q)
            S_IDLE: if (issue)      state_d = S_BUSY;
            S_BUSY: if (cnt_is_one) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // stall_ext is deliberately not merged here; the top-level hazard unit combines sources.
    assign hz          = in_busy && (multD || mfhiloD);

    assign mult_start  = issue;
    assign hilo_we     = in_busy && cnt_is_one;
    assign busy        = in_busy;
    assign stallF      = hz;
    assign stallD      = hz;
    assign flushE      = hz;
    assign cycles_left = cnt;

endmodule

// File: tb/tb_mult_hazard_ctrl.sv
module tb_mult_hazard_ctrl;

    localparam int unsigned LAT = 4;
    localparam int unsigned CW  = 3;

    logic          clk;
    logic          reset;
    logic          multD;
    logic          mfhiloD;
    logic          stall_ext;
    logic          flushD;
    logic          mult_start;
    logic          hilo_we;
    logic          busy;
    logic          stallF;
    logic          stallD;
    logic          flushE;
    logic [CW-1:0] cycles_left;

    mult_hazard_ctrl #(
        .LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .multD       (multD),
        .mfhiloD     (mfhiloD),
        .stall_ext   (stall_ext),
        .flushD      (flushD),
        .mult_start  (mult_start),
        .hilo_we     (hilo_we),
        .busy        (busy),
        .stallF      (stallF),
        .stallD      (stallD),
        .flushE      (flushE),
        .cycles_left (cycles_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       start;
        logic       we;
        logic       bsy;
        logic       hz;
        logic [2:0] cl;
    } exp_t;

    exp_t exp_q[$];
    int   start_cyc[$];
    int   we_cyc[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model state
    bit   m_busy = 1'b0;
    int   m_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    // One pipeline cycle: drive inputs, push expected outputs, compare at the negedge,
    // then advance the model across the rising edge.
    task automatic step(input bit m, input bit mf, input bit se, input bit fl);
        exp_t e;
        exp_t g;
        bit   iss;
        multD     = m;
        mfhiloD   = mf;
        stall_ext = se;
        flushD    = fl;
        iss       = !m_busy && m && !se && !fl;
        e.start   = iss;
        e.we      = m_busy && (m_cnt == 1);
        e.bsy     = m_busy;
        e.hz      = m_busy && (m || mf);
        e.cl      = 3'(m_cnt);
        exp_q.push_back(e);
        @(negedge clk);
        g = exp_q.pop_front();
        check_eq("mult_start", 32'(mult_start), 32'(g.start));
        check_eq("hilo_we", 32'(hilo_we), 32'(g.we));
        check_eq("busy", 32'(busy), 32'(g.bsy));
        check_eq("stallF", 32'(stallF), 32'(g.hz));
        check_eq("stallD", 32'(stallD), 32'(g.hz));
        check_eq("flushE", 32'(flushE), 32'(g.hz));
        check_eq("cycles_left", 32'(cycles_left), 32'(g.cl));
        if (mult_start) start_cyc.push_back(cyc);
        if (hilo_we) we_cyc.push_back(cyc);
        if (iss) begin
            m_busy = 1'b1;
            m_cnt  = LAT;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        multD     = 1'b1;
        mfhiloD   = 1'b1;
        stall_ext = 1'b0;
        flushD    = 1'b0;
        // Outputs stay quiet while reset is held, even with a mult in Decode.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_start", 32'(mult_start), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_stall", 32'(stallF), 32'd0);
        check_eq("rst_cnt", 32'(cycles_left), 32'd0);
        multD   = 1'b0;
        mfhiloD = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;

        // All-zero inputs after reset: everything stays 0.
        idle(5);

        // Single mult at t=5.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);
        check_eq("single_starts", 32'(start_cyc.size()), 32'd1);
        check_eq("single_we_cnt", 32'(we_cyc.size()), 32'd1);
        if (start_cyc.size() == 1 && we_cyc.size() == 1)
            check_eq("single_we_at", 32'(we_cyc[0] - start_cyc[0]), 32'(LAT));
        start_cyc.delete();
        we_cyc.delete();

        // Mult then a dependent mfhi held in Decode until released.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // multD held continuously: back-to-back issues spaced LAT+1 apart.
        start_cyc.delete();
        we_cyc.delete();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);
        check_eq("b2b_starts", 32'(start_cyc.size()), 32'd3);
        check_eq("b2b_wes", 32'(we_cyc.size()), 32'd3);
        if (start_cyc.size() >= 2)
            check_eq("b2b_spacing", 32'(start_cyc[1] - start_cyc[0]), 32'(LAT + 1));

        // stall_ext then flushD suppress issue; retry succeeds once clear.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        idle(2);
        // flushD while busy still raises the own hazard.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(4);

        // Random mix against the model.
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        idle(6);

        // Asynchronous reset mid-operation discards the product.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_busy", 32'(busy), 32'd0);
        check_eq("async_cnt", 32'(cycles_left), 32'd0);
        check_eq("async_we", 32'(hilo_we), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        m_busy = 1'b0;
        m_cnt  = 0;
        @(posedge clk);
        cyc++;
        #1;
        we_cyc.delete();
        idle(6);
        check_eq("async_no_we", 32'(we_cyc.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
